// File: rtl/char_buffer_arbiter_if.sv
// Write-port bundle for char_buffer_arbiter: two req/ack requesters,
// the clear request and the status pulses returned to the requesters.
// master = requester side, slave = the arbiter.
interface char_buffer_arbiter_if #(
    parameter int IDX_W  = 6,
    parameter int CHAR_W = 8
);
    logic              req_a;
    logic [IDX_W-1:0]  idx_a;
    logic [CHAR_W-1:0] data_a;
    logic              ack_a;
    logic              req_b;
    logic [IDX_W-1:0]  idx_b;
    logic [CHAR_W-1:0] data_b;
    logic              ack_b;
    logic              clear;
    logic              busy;
    logic              err;
    logic              commit;

    modport master (
        output req_a, idx_a, data_a, req_b, idx_b, data_b, clear,
        input  ack_a, ack_b, busy, err, commit
    );

    modport slave (
        input  req_a, idx_a, data_a, req_b, idx_b, data_b, clear,
        output ack_a, ack_b, busy, err, commit
    );
endinterface

// File: rtl/char_buffer_arbiter.sv
// char_buffer_arbiter: double-buffered character store for the VGA text
// controller. Two requesters write a shadow buffer through a req/ack
// arbiter; a clear request sweeps the shadow to zero one cell per cycle;
// the shadow is copied to the displayed buffer at the start of vblank.
// Optional build macro ARB_FIXED_PRIO_EN: requester A always beats B
// (otherwise round-robin, A first after reset).
module char_buffer_arbiter #(
    parameter int NUM_CHARS = 41,
    parameter int CHAR_W    = 8,
    parameter int IDX_W     = 6
) (
    input  logic                 clock_25,
    input  logic                 reset,
    input  logic                 vblank,
    char_buffer_arbiter_if.slave bus,
    output logic [CHAR_W-1:0]    char [0:NUM_CHARS-1]
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHARS - 1);
    localparam logic [IDX_W:0]   NUM_EXT  = (IDX_W + 1)'(NUM_CHARS);

    state_t            state_r;
    state_t            state_s;
    logic [IDX_W-1:0]  sweep_idx_r;
    logic              last_b_r;
    logic              vblank_d_r;
    logic              dirty_r;
    logic              pend_r;
    logic [CHAR_W-1:0] shadow_r [0:NUM_CHARS-1];

    logic              elig_a_s;
    logic              elig_b_s;
    logic              grant_a_s;
    logic              grant_b_s;
    logic              sweep_we_s;
    logic              sweep_done_s;
    logic [IDX_W-1:0]  wr_idx_s;
    logic [CHAR_W-1:0] wr_data_s;
    logic              in_range_s;
    logic              wr_en_s;
    logic              wr_err_s;
    logic              rise_s;
    logic              commit_s;
    logic              pend_s;
    logic              dirty_s;

    // A requester may not be re-granted in the cycle its ack is visible,
    // so a held request is never written twice.
    assign elig_a_s = bus.req_a & ~bus.ack_a;
    assign elig_b_s = bus.req_b & ~bus.ack_b;

    // Next-state and grant/sweep decisions; clear in IDLE beats any request.
    always_comb begin
        state_s      = state_r;
        grant_a_s    = 1'b0;
        grant_b_s    = 1'b0;
        sweep_we_s   = 1'b0;
        sweep_done_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.clear) begin
                    state_s = ST_CLEAR;
                end else begin
`ifdef ARB_FIXED_PRIO_EN
                    grant_a_s = elig_a_s;
                    grant_b_s = elig_b_s & ~elig_a_s;
`else
                    if (elig_a_s && elig_b_s) begin
                        grant_a_s = last_b_r;
                        grant_b_s = ~last_b_r;
                    end else begin
                        grant_a_s = elig_a_s;
                        grant_b_s = elig_b_s;
                    end
`endif
                end
            end
            ST_CLEAR: begin
                sweep_we_s = 1'b1;
                if (sweep_idx_r == LAST_IDX) begin
                    sweep_done_s = 1'b1;
                    state_s      = ST_IDLE;
                end else begin
                    state_s = ST_CLEAR;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Select the granted requester's write and range-check its index.
    always_comb begin
        if (grant_b_s) begin
            wr_idx_s  = bus.idx_b;
            wr_data_s = bus.data_b;
        end else begin
            wr_idx_s  = bus.idx_a;
            wr_data_s = bus.data_a;
        end
        in_range_s = ({1'b0, wr_idx_s} < NUM_EXT);
        wr_en_s    = (grant_a_s | grant_b_s) & in_range_s;
        wr_err_s   = (grant_a_s | grant_b_s) & ~in_range_s;
    end

    // Commit decision: a pending copy waits out a clear sweep, and is
    // abandoned (dirty kept) if vblank ends first.
    always_comb begin
        rise_s   = vblank & ~vblank_d_r;
        commit_s = (state_r != ST_CLEAR) & ((pend_r & vblank) | (rise_s & dirty_r));
        if (commit_s) begin
            pend_s = 1'b0;
        end else if (rise_s && dirty_r) begin
            pend_s = 1'b1;
        end else if (!vblank) begin
            pend_s = 1'b0;
        end else begin
            pend_s = pend_r;
        end
        // A write landing on the commit edge is not in this copy, so the
        // shadow stays dirty for the next frame.
        if (wr_en_s || sweep_done_s) begin
            dirty_s = 1'b1;
        end else if (commit_s) begin
            dirty_s = 1'b0;
        end else begin
            dirty_s = dirty_r;
        end
    end

    // FSM state register, sweep index and busy flag.
    always_ff @(posedge clock_25 or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            sweep_idx_r <= '0;
            bus.busy    <= 1'b0;
        end else begin
            state_r  <= state_s;
            bus.busy <= (state_s == ST_CLEAR);
            if (state_r == ST_IDLE) begin
                sweep_idx_r <= '0;
            end else if (sweep_we_s && !sweep_done_s) begin
                sweep_idx_r <= sweep_idx_r + IDX_W'(1);
            end else begin
                sweep_idx_r <= sweep_idx_r;
            end
        end
    end

    // Handshake pulses, arbitration history and commit bookkeeping.
    always_ff @(posedge clock_25 or negedge reset) begin
        if (!reset) begin
            bus.ack_a  <= 1'b0;
            bus.ack_b  <= 1'b0;
            bus.err    <= 1'b0;
            bus.commit <= 1'b0;
            last_b_r   <= 1'b1;
            vblank_d_r <= 1'b0;
            dirty_r    <= 1'b0;
            pend_r     <= 1'b0;
        end else begin
            bus.ack_a  <= grant_a_s;
            bus.ack_b  <= grant_b_s;
            bus.err    <= wr_err_s;
            bus.commit <= commit_s;
            vblank_d_r <= vblank;
            dirty_r    <= dirty_s;
            pend_r     <= pend_s;
            if (grant_a_s || grant_b_s) begin
                last_b_r <= grant_b_s;
            end else begin
                last_b_r <= last_b_r;
            end
        end
    end

    // Shadow buffer: sweep writes and granted writes never coincide.
    always_ff @(posedge clock_25 or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CHARS; i++) begin
                shadow_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CHARS; i++) begin
                if (sweep_we_s && (sweep_idx_r == IDX_W'(i))) begin
                    shadow_r[i] <= '0;
                end else if (wr_en_s && (wr_idx_s == IDX_W'(i))) begin
                    shadow_r[i] <= wr_data_s;
                end else begin
                    shadow_r[i] <= shadow_r[i];
                end
            end
        end
    end

    // Displayed buffer: changes only on a commit edge, all cells at once.
    always_ff @(posedge clock_25 or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CHARS; i++) begin
                char[i] <= '0;
            end
        end else if (commit_s) begin
            char <= shadow_r;
        end else begin
            char <= char;
        end
    end

endmodule

// File: tb/tb_char_buffer_arbiter.sv
// Self-checking bench for char_buffer_arbiter: a frame-level reference
// model (buffers as arrays, the clear sweep as a cells-left counter) is
// stepped at every rising edge and compared on every falling edge, plus
// directed scenarios with hand-computed expectations.
`timescale 1ns/1ps
module tb_char_buffer_arbiter;
    localparam int NUM_CHARS = 41;
    localparam int CHAR_W    = 8;
    localparam int IDX_W     = 6;

    logic              clock_25 = 1'b0;
    logic              reset;
    logic              vblank;
    logic [CHAR_W-1:0] char_o [0:NUM_CHARS-1];

    char_buffer_arbiter_if #(.IDX_W(IDX_W), .CHAR_W(CHAR_W)) bus ();

    char_buffer_arbiter #(
        .NUM_CHARS(NUM_CHARS),
        .CHAR_W   (CHAR_W),
        .IDX_W    (IDX_W)
    ) dut (
        .clock_25(clock_25),
        .reset   (reset),
        .vblank  (vblank),
        .bus     (bus),
        .char    (char_o)
    );

    always #5 clock_25 = ~clock_25;

    int n_pass  = 0;
    int n_total = 0;

    // reference model state
    logic [CHAR_W-1:0] m_shadow [0:NUM_CHARS-1];
    logic [CHAR_W-1:0] m_char   [0:NUM_CHARS-1];
    int  clear_left;
    bit  m_dirty, m_pend, m_vbd, m_last_b;
    bit  exp_ack_a, exp_ack_b, exp_err, exp_commit;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM_CHARS; i++) begin
            m_shadow[i] = '0;
            m_char[i]   = '0;
        end
        clear_left = 0;
        m_dirty = 0; m_pend = 0; m_vbd = 0; m_last_b = 1;
        exp_ack_a = 0; exp_ack_b = 0; exp_err = 0; exp_commit = 0;
    endtask

    task automatic model_step();
        bit rise, ea, eb, ga, gb, sweeping, cmt, wrote, done, new_pend;
        logic [IDX_W-1:0]  wi;
        logic [CHAR_W-1:0] wd;
        rise     = vblank && !m_vbd;
        sweeping = (clear_left > 0);
        ea = bus.req_a && !exp_ack_a;
        eb = bus.req_b && !exp_ack_b;
        ga = 0; gb = 0;
        if (!sweeping && !bus.clear) begin
            if (ea && eb) begin ga = m_last_b; gb = !m_last_b; end
            else begin ga = ea; gb = eb; end
        end
        cmt = !sweeping && ((m_pend && vblank) || (rise && m_dirty));
        if (cmt) m_char = m_shadow;
        if (cmt) new_pend = 0;
        else if (rise && m_dirty) new_pend = 1;
        else if (!vblank) new_pend = 0;
        else new_pend = m_pend;
        wrote = 0; exp_err = 0;
        if (ga || gb) begin
            wi = ga ? bus.idx_a : bus.idx_b;
            wd = ga ? bus.data_a : bus.data_b;
            if (int'(wi) < NUM_CHARS) begin m_shadow[wi] = wd; wrote = 1; end
            else exp_err = 1;
            m_last_b = gb;
        end
        done = 0;
        if (sweeping) begin
            m_shadow[NUM_CHARS - clear_left] = '0;
            clear_left--;
            done = (clear_left == 0);
        end else if (bus.clear) begin
            clear_left = NUM_CHARS;
        end
        if (wrote || done) m_dirty = 1;
        else if (cmt) m_dirty = 0;
        m_pend = new_pend;
        m_vbd = vblank;
        exp_ack_a = ga; exp_ack_b = gb; exp_commit = cmt;
    endtask

    task automatic compare_all();
        int bad;
        check("ack_a", bus.ack_a, exp_ack_a);
        check("ack_b", bus.ack_b, exp_ack_b);
        check("err", bus.err, exp_err);
        check("commit", bus.commit, exp_commit);
        check("busy", bus.busy, clear_left > 0);
        bad = 0;
        for (int i = NUM_CHARS - 1; i >= 0; i--) if (char_o[i] !== m_char[i]) bad = i;
        check($sformatf("char[%0d]", bad), char_o[bad], m_char[bad]);
    endtask

    // one clock: model advances on the rising edge, outputs compared on the falling edge
    task automatic tick();
        @(posedge clock_25);
        if (!reset) model_reset();
        else model_step();
        @(negedge clock_25);
        compare_all();
    endtask

    task automatic check_all_zero(input string name);
        int bad;
        bad = 0;
        for (int i = NUM_CHARS - 1; i >= 0; i--) if (char_o[i] !== '0) bad = i;
        check($sformatf("%s[%0d]", name, bad), char_o[bad], 32'd0);
    endtask

    task automatic new_a();
        bus.idx_a  = ($urandom_range(0, 9) == 0) ? IDX_W'($urandom_range(41, 63)) : IDX_W'($urandom_range(0, 40));
        bus.data_a = CHAR_W'($urandom);
    endtask

    task automatic new_b();
        bus.idx_b  = ($urandom_range(0, 9) == 0) ? IDX_W'($urandom_range(41, 63)) : IDX_W'($urandom_range(0, 40));
        bus.data_b = CHAR_W'($urandom);
    endtask

    initial begin
        int n;
        int vcnt;
        reset = 1'b0; vblank = 1'b0;
        bus.req_a = 1'b0; bus.idx_a = '0; bus.data_a = '0;
        bus.req_b = 1'b0; bus.idx_b = '0; bus.data_b = '0;
        bus.clear = 1'b0;
        model_reset();
        repeat (3) tick();
        check("rst_busy", bus.busy, 32'd0);
        check("rst_commit", bus.commit, 32'd0);
        check("rst_ack_a", bus.ack_a, 32'd0);
        check("rst_char5", char_o[5], 32'd0);
        reset = 1'b1;
        tick();

        // single write during active video, shown at the next vblank rise
        bus.req_a = 1'b1; bus.idx_a = 6'd5; bus.data_a = 8'd65;
        tick();
        check("wr_ack_a", bus.ack_a, 32'd1);
        check("wr_char5_hidden", char_o[5], 32'd0);
        bus.req_a = 1'b0;
        tick(); tick();
        vblank = 1'b1;
        tick();
        check("wr_commit", bus.commit, 32'd1);
        check("wr_char5", char_o[5], 32'd65);
        vblank = 1'b0;
        tick();

        // out-of-range index: acked with err, no write, no commit
        bus.req_b = 1'b1; bus.idx_b = 6'd41; bus.data_b = 8'd7;
        tick();
        check("oor_ack_b", bus.ack_b, 32'd1);
        check("oor_err", bus.err, 32'd1);
        bus.req_b = 1'b0;
        tick();
        vblank = 1'b1;
        tick();
        check("oor_no_commit", bus.commit, 32'd0);
        vblank = 1'b0;
        tick();

        // both requesters held: grants alternate, A first
        bus.req_a = 1'b1; bus.idx_a = 6'd1; bus.data_a = 8'h11;
        bus.req_b = 1'b1; bus.idx_b = 6'd2; bus.data_b = 8'h22;
        for (int k = 0; k < 6; k++) begin
            tick();
            check($sformatf("alt_ack_a%0d", k), bus.ack_a, (k % 2 == 0) ? 32'd1 : 32'd0);
            check($sformatf("alt_ack_b%0d", k), bus.ack_b, (k % 2 == 1) ? 32'd1 : 32'd0);
        end
        bus.req_a = 1'b0; bus.req_b = 1'b0;
        tick(); tick();

        // clear sweep with vblank rising mid-sweep and A waiting
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        bus.req_a = 1'b1; bus.idx_a = 6'd10; bus.data_a = 8'h55;
        n = 0;
        while (bus.busy && n < 100) begin
            n++;
            if (n == 10) vblank = 1'b1;
            tick();
        end
        check("clr_busy_len", n, 32'd41);
        check("clr_deferred", bus.commit, 32'd0);
        tick();
        check("clr_commit", bus.commit, 32'd1);
        check("clr_ack_a", bus.ack_a, 32'd1);
        check_all_zero("clr_char");
        bus.req_a = 1'b0;
        tick();
        vblank = 1'b0;
        tick(); tick();
        vblank = 1'b1;
        tick();
        check("late_commit", bus.commit, 32'd1);
        check("late_char10", char_o[10], 32'h55);
        vblank = 1'b0;
        tick();

        // asynchronous reset in the middle of a sweep
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        repeat (5) tick();
        reset = 1'b0;
        #1;
        check("mid_rst_busy", bus.busy, 32'd0);
        check("mid_rst_ack_a", bus.ack_a, 32'd0);
        check_all_zero("mid_rst_char");
        model_reset();
        tick(); tick();
        reset = 1'b1;
        bus.req_a = 1'b1; bus.idx_a = 6'd3; bus.data_a = 8'h33;
        bus.req_b = 1'b1; bus.idx_b = 6'd4; bus.data_b = 8'h44;
        tick();
        check("post_rst_ack_a", bus.ack_a, 32'd1);
        check("post_rst_ack_b", bus.ack_b, 32'd0);

        // randomized traffic against the model
        vcnt = 20;
        for (int c = 0; c < 3000; c++) begin
            tick();
            if (bus.req_a) begin
                if (bus.ack_a) begin
                    if ($urandom_range(0, 3) == 0) bus.req_a = 1'b0;
                    else new_a();
                end
            end else if ($urandom_range(0, 2) == 0) begin
                bus.req_a = 1'b1; new_a();
            end
            if (bus.req_b) begin
                if (bus.ack_b) begin
                    if ($urandom_range(0, 3) == 0) bus.req_b = 1'b0;
                    else new_b();
                end
            end else if ($urandom_range(0, 2) == 0) begin
                bus.req_b = 1'b1; new_b();
            end
            bus.clear = ($urandom_range(0, 149) == 0);
            if (vcnt == 0) begin
                vblank = ~vblank;
                vcnt = vblank ? int'($urandom_range(3, 50)) : int'($urandom_range(15, 60));
            end else begin
                vcnt--;
            end
        end
        bus.req_a = 1'b0; bus.req_b = 1'b0; bus.clear = 1'b0;
        tick(); tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
